// File: rtl/teclado_pkg.sv
// Shared types for the bicycle-rack keypad front end: FSM states, key index
// and the fixed-priority selector used when several keys press together.
package teclado_pkg;

  localparam int N_TECLAS = 4;

  typedef logic [1:0] tecla_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    EMIT,
    WAIT_REL
  } estado_t;

  // Lowest index wins: key 1 has priority over 2, 3 and 4.
  function automatic tecla_t prioridad(input logic [N_TECLAS-1:0] press);
    tecla_t sel;
    sel = '0;
    for (int i = N_TECLAS - 1; i >= 0; i--) begin
      if (press[i]) sel = tecla_t'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/sincronizador_antirrebote.sv
// One key line: 2-FF synchroniser, stable-count debouncer and a one-cycle
// pulse on every debounced rising edge.
module sincronizador_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic db,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             db_prev_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      cnt        <= '0;
      db         <= 1'b0;
      db_prev_p2 <= 1'b0;
      press      <= 1'b0;
    end else begin
      // synchroniser stage
      sync_p0 <= boton;
      sync_p1 <= sync_p0;
      // debounce stage: any return to the current level restarts the count
      if (sync_p1 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // edge stage: releases deliberately produce nothing
      db_prev_p2 <= db;
      press      <= db & ~db_prev_p2;
    end
  end

endmodule

// File: rtl/antirrebote_teclado.sv
// Keypad front end: four debounced key lines arbitrated into a single pending
// key, released to the keypad FSM as a one-cycle one-hot strobe on rtecla.
module antirrebote_teclado
  import teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic boton1,
  input  logic boton2,
  input  logic boton3,
  input  logic boton4,
  input  logic rtecla,
  output logic entrada1,
  output logic entrada2,
  output logic entrada3,
  output logic entrada4,
  output logic tecla_pendiente,
  output logic ocupado
);

  logic [N_TECLAS-1:0] botones;
  logic [N_TECLAS-1:0] db;
  logic [N_TECLAS-1:0] press;

  estado_t             estado;
  estado_t             estado_sig;
  tecla_t              key_q;
  tecla_t              key_sig;
  logic                rtecla_p0;
  logic [N_TECLAS-1:0] entrada_q;
  logic [N_TECLAS-1:0] entrada_sig;

  assign botones = {boton4, boton3, boton2, boton1};

  for (genvar i = 0; i < N_TECLAS; i++) begin : g_tecla
    sincronizador_antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_sinc (
      .clk  (clk),
      .reset(reset),
      .boton(botones[i]),
      .db   (db[i]),
      .press(press[i])
    );
  end

  // Presses outside IDLE are dropped on purpose: no queue, no auto-repeat.
  always_comb begin
    estado_sig  = estado;
    key_sig     = key_q;
    entrada_sig = '0;
    case (estado)
      IDLE: begin
        if (|press) begin
          key_sig    = prioridad(press);
          estado_sig = PEND;
        end
      end
      PEND:     if (rtecla_p0) estado_sig = EMIT;
      EMIT:     estado_sig = WAIT_REL;
      WAIT_REL: if (db == '0) estado_sig = IDLE;
      default:  estado_sig = IDLE;
    endcase
    if (estado_sig == EMIT) entrada_sig[key_sig] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= IDLE;
      key_q     <= '0;
      rtecla_p0 <= 1'b0;
      entrada_q <= '0;
    end else begin
      estado    <= estado_sig;
      key_q     <= key_sig;
      rtecla_p0 <= rtecla;
      entrada_q <= entrada_sig;
    end
  end

  assign entrada1        = entrada_q[0];
  assign entrada2        = entrada_q[1];
  assign entrada3        = entrada_q[2];
  assign entrada4        = entrada_q[3];
  assign tecla_pendiente = (estado == PEND);
  assign ocupado         = (estado != IDLE);

endmodule

// File: tb/tb_antirrebote_teclado.sv
// Bench for antirrebote_teclado with a short debounce: vector table, corner
// sequences and a random run against a window-based reference model.
module tb_antirrebote_teclado;

  localparam int D = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       rtecla = 1'b0;
  logic [3:0] bot    = '0;
  logic       entrada1, entrada2, entrada3, entrada4;
  logic       tecla_pendiente, ocupado;
  logic [3:0] ent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_strobe = 0;
  int last_cyc = -1;
  int last_key = 0;
  int multi_hot = 0;
  bit cmp_model = 1'b0;

  always #5 clk = ~clk;

  assign ent = {entrada4, entrada3, entrada2, entrada1};

  antirrebote_teclado #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .boton1         (bot[0]),
    .boton2         (bot[1]),
    .boton3         (bot[2]),
    .boton4         (bot[3]),
    .rtecla         (rtecla),
    .entrada1       (entrada1),
    .entrada2       (entrada2),
    .entrada3       (entrada3),
    .entrada4       (entrada4),
    .tecla_pendiente(tecla_pendiente),
    .ocupado        (ocupado)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a key level flips once the raw line, seen two edges
  // late, has disagreed with it for D consecutive edges.
  logic [3:0] hq[$];
  logic [3:0] m_db, m_db_prev, m_press, m_ent;
  logic       m_rq;
  int         m_phase;  // 0 idle, 1 pending, 2 emitting, 3 waiting release
  int         m_key;

  task automatic model_reset();
    hq.delete();
    repeat (D + 2) hq.push_back(4'b0000);
    m_db = '0; m_db_prev = '0; m_press = '0; m_ent = '0;
    m_rq = 1'b0; m_phase = 0; m_key = 0;
  endtask

  task automatic model_edge();
    logic [3:0] flip;
    hq.push_back(bot);
    if (hq.size() > D + 2) void'(hq.pop_front());
    for (int i = 0; i < 4; i++) begin
      flip[i] = 1'b1;
      for (int k = 0; k < D; k++)
        if (hq[k][i] == m_db[i]) flip[i] = 1'b0;
    end
    case (m_phase)
      0: if (m_press != 0) begin
           for (int i = 3; i >= 0; i--) if (m_press[i]) m_key = i;
           m_phase = 1;
         end
      1: if (m_rq) m_phase = 2;
      2: m_phase = 3;
      default: if (m_db == 0) m_phase = 0;
    endcase
    m_press   = m_db & ~m_db_prev;
    m_db_prev = m_db;
    m_db      = m_db ^ flip;
    m_rq      = rtecla;
    m_ent     = (m_phase == 2) ? 4'(1 << m_key) : 4'b0000;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    cyc++;
    if (ent != 0) begin
      n_strobe++;
      last_cyc = cyc;
      for (int i = 0; i < 4; i++) if (ent[i]) last_key = i + 1;
    end
    if ($countones(ent) > 1) multi_hot++;
    if (cmp_model)
      check("model", int'({ent, tecla_pendiente, ocupado}),
            int'({m_ent, m_phase == 1, m_phase != 0}));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_out", int'({ent, tecla_pendiente, ocupado}), 0);
    step();
    step();
    reset = 1'b1;
    n_strobe = 0; multi_hot = 0; last_cyc = -1; last_key = 0;
  endtask

  typedef struct {
    logic [3:0] mask;
    int         key;
  } vec_t;

  vec_t tbl[6];
  int   seg[6];
  int   dur[4];
  int   t0, t1, r;

  initial begin
    tbl[0] = '{mask: 4'b0010, key: 2};
    tbl[1] = '{mask: 4'b0001, key: 1};
    tbl[2] = '{mask: 4'b1001, key: 1};
    tbl[3] = '{mask: 4'b1100, key: 3};
    tbl[4] = '{mask: 4'b1000, key: 4};
    tbl[5] = '{mask: 4'b0110, key: 2};
    seg = '{3, 2, 5, 2, 2, 2};
    model_reset();

    // Clean presses and simultaneous-press priority.
    for (int i = 0; i < 6; i++) begin
      bot = '0; rtecla = 1'b1;
      do_reset();
      bot = tbl[i].mask;
      t0 = cyc + 1;
      repeat (30) step();
      check("tbl_strobes", n_strobe, 1);
      check("tbl_key", last_key, tbl[i].key);
      check("tbl_time", last_cyc, t0 + D + 4);
      check("tbl_onehot", multi_hot, 0);
      bot = '0;
      repeat (14) step();
      check("tbl_idle", int'(ocupado), 0);
    end

    // Bounce: 3/5/2-cycle high glitches, then a steady press.
    bot = '0; rtecla = 1'b1;
    do_reset();
    for (int s = 0; s < 6; s++) begin
      bot[0] = (s % 2 == 0);
      repeat (seg[s]) step();
    end
    bot[0] = 1'b1;
    t0 = cyc + 1;
    repeat (30) step();
    check("bounce_strobes", n_strobe, 1);
    check("bounce_key", last_key, 1);
    check("bounce_time", last_cyc, t0 + D + 4);

    // Backpressure: key held pending while rtecla is low.
    bot = '0; rtecla = 1'b0;
    do_reset();
    bot = 4'b0100;
    repeat (50) step();
    check("bp_pending", int'(tecla_pendiente), 1);
    check("bp_no_strobe", n_strobe, 0);
    rtecla = 1'b1;
    r = cyc;
    step();
    check("bp_early", n_strobe, 0);
    step();
    check("bp_time", last_cyc, r + 2);
    check("bp_key", last_key, 3);

    // Simultaneous 1+4, then release 1 while 4 stays held.
    bot = '0; rtecla = 1'b1;
    do_reset();
    bot = 4'b1001;
    repeat (30) step();
    check("sim_key", last_key, 1);
    bot = 4'b1000;
    repeat (40) step();
    check("sim_strobes", n_strobe, 1);
    check("sim_busy", int'(ocupado), 1);
    bot = '0;
    repeat (15) step();
    check("sim_idle", int'(ocupado), 0);
    check("sim_final", n_strobe, 1);

    // Long hold: single strobe, release latency, then a re-press.
    bot = '0; rtecla = 1'b1;
    do_reset();
    bot = 4'b0010;
    t0 = cyc + 1;
    repeat (200) step();
    check("hold_strobes", n_strobe, 1);
    check("hold_time", last_cyc, t0 + D + 4);
    check("hold_busy", int'({tecla_pendiente, ocupado}), 1);
    bot = '0;
    repeat (D + 2) step();
    check("rel_still_busy", int'(ocupado), 1);
    step();
    check("rel_idle", int'(ocupado), 0);
    bot = 4'b0010;
    t1 = cyc + 1;
    repeat (20) step();
    check("repress_strobes", n_strobe, 2);
    check("repress_time", last_cyc, t1 + D + 4);

    // Asynchronous reset during the strobe cycle.
    bot = '0; rtecla = 1'b1;
    do_reset();
    bot = 4'b0010;
    repeat (D + 5) step();
    check("emit_seen", int'(ent), 2);
    reset = 1'b0;
    #1;
    check("rst_emit_out", int'({ent, tecla_pendiente, ocupado}), 0);
    step();
    step();
    reset = 1'b1;
    n_strobe = 0;
    t1 = cyc + 1;
    step();
    check("rst_idle", int'(ocupado), 0);
    repeat (29) step();
    check("rst_restrobe", n_strobe, 1);
    check("rst_restrobe_time", last_cyc, t1 + D + 4);

    // Random run against the reference model, with one reset in the middle.
    bot = '0; rtecla = 1'b0;
    do_reset();
    cmp_model = 1'b1;
    for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 20);
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          bot[i] = ~bot[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7)
                                               : $urandom_range(8, 40);
        end
      end
      if ($urandom_range(0, 9) == 0) rtecla = ~rtecla;
      if (n == 2000) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end
      step();
    end
    cmp_model = 1'b0;
    check("rand_onehot", multi_hot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/antirrebote_teclado.md
# antirrebote_teclado

Front-end conditioning stage for the bicycle-rack keypad. It takes four raw, bouncing, asynchronous push-button lines and synchronises and debounces each one. It turns every clean press into exactly one single-cycle one-hot strobe on `entrada1`..`entrada4`, which feed the keypad FSM directly. A press is held pending until the downstream FSM signals readiness on `rtecla`, so no key is lost while the FSM is busy.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` input 1: single system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces every register to its reset value immediately.
- `boton1`..`boton4` input 1 each: raw key lines, active-high, asynchronous, bouncing.
- `rtecla` input 1: downstream ready-for-key, level.
- `entrada1`..`entrada4` output 1 each: one-hot key strobe, one cycle wide, registered.
- `tecla_pendiente` output 1: a key is latched and awaiting `rtecla`.
- `ocupado` output 1: high in any state other than IDLE.

## Operation

**Per key (x4): synchroniser and debounce.**
- 2-FF synchroniser produces `sync[i]`.
- Debounced level `db[i]` with counter `cnt[i]`:
  - `sync == db`: `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - When `cnt == DEBOUNCE_CYCLES-1` and the inputs still differ: `db <= sync` and `cnt <= 0`.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never changes `db`.
- `press[i]` is a registered single-cycle pulse the cycle after `db[i]` rises.
- Releases generate no pulse.

**Control FSM.** States are IDLE, PEND, EMIT, WAIT_REL.
- **IDLE:** any `press` latches a key index into `key_q` and moves to PEND.
  - Simultaneous presses use fixed priority 1 > 2 > 3 > 4. Lower-priority presses in the same cycle are discarded.
- **PEND:** `tecla_pendiente = 1`. When `rtecla` is sampled 1, move to EMIT. `key_q` is held indefinitely while `rtecla = 0`.
- **EMIT:** `entrada[key_q]` is 1 for exactly this cycle, then move to WAIT_REL.
- **WAIT_REL:** stay until all four `db` are 0, then move to IDLE.
- Presses arriving in PEND, EMIT or WAIT_REL are ignored, including second keys and re-presses. There is no queue and no auto-repeat.
- Strobe outputs are registered and decoded from the state and `key_q`. At most one `entradaN` is high in any cycle.

**Reset values:**
- All `entrada*`, `tecla_pendiente` and `ocupado` are 0.
- State is IDLE; `key_q`, all `db`, `cnt` and synchroniser flops are 0.
- Reset asserted mid-operation, including during EMIT, clears the output immediately (asynchronously) and discards the pending key.
- After reset deasserts, a key still physically held must be re-debounced. It produces a strobe once `db` rises, because `db` restarts at 0.

## Timing

- Clean input rising at edge 0 with `rtecla` held 1: `entradaN` is high during cycle `DEBOUNCE_CYCLES+4`. This comprises the 2 synchroniser cycles, the `DEBOUNCE_CYCLES` count, 1 cycle to register `press`, 1 cycle for IDLE→PEND, and 1 cycle for PEND→EMIT. Tolerance is 0 cycles.
- With `rtecla = 0`, the strobe occurs 2 cycles after the first edge at which `rtecla` is sampled 1.
- Release latency: `DEBOUNCE_CYCLES+2` cycles from the clean falling edge until the FSM can leave WAIT_REL.
- Minimum spacing between two accepted strobes is bounded by the release debounce plus the next press debounce.

## Structure

- Package `teclado_pkg`:
  - state enum (IDLE, PEND, EMIT, WAIT_REL)
  - `N_TECLAS = 4`
  - key-index type (2 bits)
- Sub-module `sincronizador_antirrebote`, instantiated 4 times:
  - contains the 2-FF synchroniser, debounce counter and rising-edge pulse
  - parameters `DEBOUNCE_CYCLES`, `CNT_W`
  - outputs `db` and `press`
- The top level holds the arbitration, the FSM and the strobe registers.

## Test plan

All tests use `DEBOUNCE_CYCLES = 8`.
- **Clean press:** `boton2` goes 0→1 and is held, with `rtecla = 1`. `entrada2` is high for exactly 1 cycle, 12 cycles after the edge. No other `entrada` toggles.
- **Bounce:** `boton1` toggles with high pulses of 3, 5 and 2 cycles, then is held high. Exactly one `entrada1` strobe occurs, timed from the final stable edge.
- **Backpressure:** `boton3` is pressed with `rtecla = 0` for 50 cycles. `tecla_pendiente = 1` and there is no strobe. When `rtecla` rises, `entrada3` pulses 2 cycles later.
- **Simultaneous:** `boton1` and `boton4` rise on the same edge. Only `entrada1` pulses. Releasing `boton1` while `boton4` is still held produces no further strobe.
- **Hold/no repeat:** `boton2` is held for 200 cycles. One strobe occurs and the FSM remains in WAIT_REL until release. A re-press after the debounced release produces a second strobe.
- **Async reset mid-EMIT:** `reset` is driven to 0 during the EMIT cycle. `entrada*` drop within that cycle and all outputs are 0. After release the FSM is in IDLE, and the held key re-strobes after a full debounce.
